// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the decode-stage immediate generator: format codes, RV32I opcodes
// and the result record held in the output stage.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_SH = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Fields are sized for the widest supported instance; narrower tops use the low bits.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 64;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        fmt_e                 fmt;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
    } imm_res_t;

endpackage

// File: rtl/imm_gen_pipe_decode_comb.sv
// Purely combinational RV32I immediate extraction: instruction -> {imm, fmt, illegal}.
// Every immediate is built as a 32-bit value whose bit 31 is the sign, then widened to XLEN.
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];

    always_comb begin
        imm32   = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    fmt   = FMT_SH;
                    imm32 = {27'b0, instruction[24:20]};
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{instruction[31]}}, instruction[31:20]};
                end
            end
            OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                fmt   = FMT_I;
                imm32 = {{20{instruction[31]}}, instruction[31:20]};
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instruction[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
            end
            OP_REG: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Shift amounts have bit 31 clear, so a signed widening is correct for every format.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry (main + skid) output stage so that
// in_ready can be a flop while throughput stays at one result per cycle.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int INSTRUCTION = 32,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTRUCTION-1:0] instruction,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        imm,
    output fmt_e                   fmt,
    output logic                   illegal,
    output logic [TAG_W-1:0]       out_tag
);

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    imm_res_t        dec_res;
    imm_res_t        main_q;
    imm_res_t        skid_q;
    logic            main_valid;
    logic            skid_valid;
    logic            accept;
    logic            main_free;
    logic            unused_hi;

    imm_decode_comb #(.XLEN(XLEN)) u_decode (
        .instruction (instruction),
        .imm         (dec_imm),
        .fmt         (dec_fmt),
        .illegal     (dec_illegal)
    );

    always_comb begin
        dec_res         = '0;
        dec_res.imm     = IMM_MAX_W'(dec_imm);
        dec_res.fmt     = dec_fmt;
        dec_res.illegal = dec_illegal;
        dec_res.tag     = TAG_MAX_W'(in_tag);
    end

    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    // The skid entry is always older than the input, so it refills main first; while the
    // skid is occupied in_ready is low, so an input never competes with a skid drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec_res;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec_res;
            skid_valid <= 1'b1;
        end
    end

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign imm       = main_q.imm[XLEN-1:0];
    assign fmt       = main_q.fmt;
    assign illegal   = main_q.illegal;
    assign out_tag   = main_q.tag[TAG_W-1:0];

    // Upper struct bits beyond XLEN/TAG_W are constant zero in narrow instances.
    assign unused_hi = ^{main_q.imm, main_q.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit instance for formats, backpressure, flush and
// reset, plus a 64-bit instance for wide sign extension.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instruction = '0;
    logic [31:0] in_tag = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
    logic [31:0] out_tag;

    logic        in64_valid = 1'b0;
    logic        out64_ready = 1'b1;
    logic [31:0] instr64 = '0;
    logic [31:0] in_tag64 = 32'h64;
    logic        in64_ready;
    logic        out64_valid;
    logic [63:0] imm64;
    fmt_e        fmt64;
    logic        illegal64;
    logic [31:0] tag64;

    imm_gen_pipe #(.INSTRUCTION(32), .XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fmt(fmt), .illegal(illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.INSTRUCTION(32), .XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(1'b0),
        .in_valid(in64_valid), .in_ready(in64_ready),
        .instruction(instr64), .in_tag(in_tag64),
        .out_valid(out64_valid), .out_ready(out64_ready),
        .imm(imm64), .fmt(fmt64), .illegal(illegal64), .out_tag(tag64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t pending;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   stall_left = 0;
    bit   accepted = 1'b0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Compares the presented result against the scoreboard head; pops on a transfer.
    task automatic check_output();
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("[TB] FAIL unexpected_output observed=tag_%0h expected=no_output", out_tag);
            end else begin
                e = sb[0];
                chk("imm", {32'b0, imm}, {32'b0, e.imm});
                chk("fmt", 64'(fmt), 64'(e.fmt));
                chk("illegal", 64'(illegal), 64'(e.ill));
                chk("tag", {32'b0, out_tag}, {32'b0, e.tag});
                if (out_ready) begin
                    void'(sb.pop_front());
                    if (e.lat) chk("latency", 64'(cyc), 64'(e.acc + 1));
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_output();
        if (flush_i) sb.delete();
        else if (in_valid && in_ready) begin
            pending.acc = cyc;
            sb.push_back(pending);
            accepted = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) out_ready = 1'b1;
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] ins, input logic [31:0] tag,
                                  input logic [31:0] e_imm, input fmt_e e_fmt,
                                  input logic e_ill, input bit lat);
        pending.imm = e_imm;
        pending.fmt = e_fmt;
        pending.ill = e_ill;
        pending.tag = tag;
        pending.acc = 0;
        pending.lat = lat;
        instruction = ins;
        in_tag      = tag;
        in_valid    = 1'b1;
        accepted    = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) step();
        in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $error("[TB] FAIL accept_timeout observed=not_accepted expected=accepted tag=%0h", tag);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) step();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", {32'b0, imm}, 64'd0);
        chk("rst_fmt", 64'(fmt), 64'(FMT_R));
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_tag", {32'b0, out_tag}, 64'd0);
        chk("rst_out64_valid", 64'(out64_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Individual formats, back to back with out_ready high.
        out_ready = 1'b1;
        apply_stimulus(32'hFFF00093, 32'h101, 32'hFFFFFFFF, FMT_I,  1'b0, 1'b1);
        apply_stimulus(32'hFE112E23, 32'h102, 32'hFFFFFFFC, FMT_S,  1'b0, 1'b1);
        apply_stimulus(32'hFE000CE3, 32'h103, 32'hFFFFFFF8, FMT_B,  1'b0, 1'b1);
        apply_stimulus(32'h123450B7, 32'h104, 32'h12345000, FMT_U,  1'b0, 1'b1);
        apply_stimulus(32'h008000EF, 32'h105, 32'h00000008, FMT_J,  1'b0, 1'b1);
        apply_stimulus(32'h4030D093, 32'h106, 32'h00000003, FMT_SH, 1'b0, 1'b1);
        apply_stimulus(32'h0000007F, 32'hABCD, 32'h0,       FMT_R,  1'b1, 1'b1);
        drain(3);

        // Backpressure: four inputs, out_ready low for three cycles.
        out_ready  = 1'b0;
        stall_left = 3;
        apply_stimulus(32'h00100093, 32'd1, 32'd1, FMT_I, 1'b0, 1'b0);
        apply_stimulus(32'h00200093, 32'd2, 32'd2, FMT_I, 1'b0, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        apply_stimulus(32'h00300093, 32'd3, 32'd3, FMT_I, 1'b0, 1'b0);
        apply_stimulus(32'h00400093, 32'd4, 32'd4, FMT_I, 1'b0, 1'b0);
        drain(4);

        // Flush with both entries held and an input presented in the same cycle.
        out_ready  = 1'b0;
        stall_left = 0;
        apply_stimulus(32'h01000093, 32'h20, 32'h10, FMT_I, 1'b0, 1'b0);
        apply_stimulus(32'h01100093, 32'h21, 32'h11, FMT_I, 1'b0, 1'b0);
        chk("flush_pre_in_ready", 64'(in_ready), 64'd0);
        instruction = 32'h01200093;
        in_tag      = 32'h22;
        in_valid    = 1'b1;
        flush_i     = 1'b1;
        step();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drain(3);

        // 64-bit instance: sign extension above bit 31.
        instr64    = 32'h800000B7;
        in64_valid = 1'b1;
        @(negedge clk);
        chk("x64_in_ready", 64'(in64_ready), 64'd1);
        @(posedge clk);
        #1;
        instr64 = 32'hFFF00093;
        @(negedge clk);
        chk("x64_lui_valid", 64'(out64_valid), 64'd1);
        chk("x64_lui_imm", imm64, 64'hFFFFFFFF80000000);
        chk("x64_lui_fmt", 64'(fmt64), 64'(FMT_U));
        chk("x64_lui_tag", {32'b0, tag64}, 64'h64);
        @(posedge clk);
        #1;
        in64_valid = 1'b0;
        @(negedge clk);
        chk("x64_addi_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
        chk("x64_addi_illegal", 64'(illegal64), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a stalled transfer.
        out_ready = 1'b0;
        apply_stimulus(32'h00700093, 32'h30, 32'h7, FMT_I, 1'b0, 1'b0);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_imm", {32'b0, imm}, 64'd0);
        chk("async_rst_tag", {32'b0, out_tag}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        apply_stimulus(32'hFFF00093, 32'h40, 32'hFFFFFFFF, FMT_I, 1'b0, 1'b1);
        drain(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage. It covers every RV32I immediate format: I, S, B, U, J, plus shift-amount. It also emits a format code and an illegal-opcode flag. It sits between fetch/instruction buffer and register-read, adds one cycle of latency, and sustains full throughput under downstream backpressure through a 2-entry skid stage.

Parameters:
INSTRUCTION, 32, instruction width in bits (fixed 32 for RV32I).
XLEN, 32, immediate output width; 32 or 64, sign-extension fills to XLEN.
TAG_W, 32, width of sideband tag (typically PC) carried alongside the instruction.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush_i  input  1  synchronous flush; drops all held entries.
in_valid  input  1  upstream instruction valid.
in_ready  output  1  block can accept; registered.
instruction  input  INSTRUCTION  raw instruction word.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts.
imm  output  XLEN  generated immediate.
fmt  output  3  format code from the shared package.
illegal  output  1  opcode not in the RV32I set.
out_tag  output  TAG_W  tag of the result entry.

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, imm=0, fmt=FMT_R, illegal=0, out_tag=0, skid empty.
- Transfer occurs when valid&&ready on the same edge. Latency is exactly 1 cycle from input transfer to out_valid. Throughput is 1 per cycle while out_ready=1.
- Decode by opcode [6:0]:
  - 0010011 OP-IMM: I format. When funct3 is 001 or 101, fmt=FMT_SH and imm is the zero-extended shamt [24:20]; bit 30 is not part of imm.
  - 0000011 LOAD, 1100111 JALR, 0001111 FENCE, 1110011 SYSTEM: I format, imm = sext([31:20]).
  - 0100011: S format, imm = sext({[31:25],[11:7]}).
  - 1100011: B format, imm = sext({[31],[7],[30:25],[11:8],1'b0}).
  - 0110111 and 0010111: U format, imm = sext({[31:12],12'b0}).
  - 1101111: J format, imm = sext({[31],[19:12],[20],[30:21],1'b0}).
  - 0110011: FMT_R, imm=0.
  - Any other opcode: illegal=1, fmt=FMT_R, imm=0. The entry still flows through; it is not dropped.
- Sign extension is always from instruction bit 31 to XLEN. For XLEN=64, U-imm is sign-extended above bit 31.
- Output stage:
  - Main register holds the presented result.
  - Skid register captures an accepted input when the main register is full and out_ready=0.
  - in_ready = !skid_full (registered).
- Simultaneous events:
  - Output drains and input arrives in the same cycle: main reloads from skid if the skid is occupied, else from the input. Order is strictly FIFO.
  - Main empty: input goes directly to main.
- Output stability: out_valid, imm, fmt, illegal and out_tag hold stable while out_valid&&!out_ready.
- flush_i has priority over all transfers. The next cycle out_valid=0, skid empty, in_ready=1. An input presented in the flush cycle is discarded.
- Reset mid-operation: all entries are lost immediately and outputs go to their reset values.

Decomposition:
- Package imm_gen_pkg holds:
  - fmt_e enum (3 bits): FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH.
  - Opcode localparams.
  - A packed struct imm_res_t {imm, fmt, illegal, tag} used for both holding registers.
- Sub-module imm_decode_comb: purely combinational instruction→{imm, fmt, illegal}, parametrised by XLEN. The top contains only the skid and handshake logic.

Test Plan:
1. Individual formats, each with out_ready=1: 0xFFF00093 (addi -1) → imm=0xFFFFFFFF, FMT_I; 0xFE112E23 (sw -4) → 0xFFFFFFFC, FMT_S; 0xFE000CE3 (beq -8) → 0xFFFFFFF8, FMT_B. Each result appears exactly one cycle after acceptance.
2. 0x123450B7 (lui) → 0x12345000, FMT_U; 0x008000EF (jal +8) → 0x00000008, FMT_J; 0x4030D093 (srai 3) → 0x00000003, FMT_SH.
3. 0x0000007F → illegal=1, imm=0, fmt=FMT_R, out_tag preserved.
4. Backpressure:
   - Stimulus: four back-to-back inputs with tags 1..4; out_ready held 0 for 3 cycles, then 1.
   - Response: in_ready deasserts after 2 entries are held. Outputs appear in order 1,2,3,4 with none lost or duplicated, and imm is stable while stalled.
5. Flush: with both entries held, assert flush_i together with in_valid → next cycle out_valid=0 and in_ready=1; the flushed-cycle input never appears.
6. XLEN=64 instance: 0x800000B7 (lui) → 0xFFFFFFFF80000000. Also assert rst_n low mid-stream → out_valid=0 asynchronously.
